// File: rtl/pwm_dynamic_multi.sv
// Multi-channel PWM on a shared prescaled time base; duty writes land in shadow registers and
// are promoted to the active set only at the period wrap. Optional: PWM_DYNAMIC_MULTI_FADE_EN.
module pwm_dynamic_multi #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned RES      = 8,
  parameter int unsigned PRESCALE = 100000,
  parameter int unsigned CH_W     = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] enable,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [RES-1:0]      wr_duty,
  output logic [CHANNELS-1:0] pwm,
  output logic                period_start
);

  localparam int unsigned    PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(PRESCALE - 1);
  // Counter stops at 2^RES-2 so that duty 2^RES-1 is high for the whole period.
  localparam logic [RES-1:0] CNT_LAST   = {{(RES - 1){1'b1}}, 1'b0};

  logic [PW-1:0]       presc_q, presc_d;
  logic [RES-1:0]      cnt_q, cnt_d;
  logic [RES-1:0]      shadow_q [CHANNELS];
  logic [RES-1:0]      shadow_d [CHANNELS];
  logic [RES-1:0]      active_q [CHANNELS];
  logic [RES-1:0]      active_d [CHANNELS];
  logic [CHANNELS-1:0] pwm_d;
  logic                tick, wrap;

  assign tick = (presc_q == PRESC_LAST);
  assign wrap = tick && (cnt_q == CNT_LAST);

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    cnt_d   = cnt_q;
    if (tick) begin
      cnt_d = wrap ? '0 : cnt_q + RES'(1);
    end
    for (int i = 0; i < CHANNELS; i++) begin
      // Out-of-range channel selects match no index and are dropped.
      shadow_d[i] = shadow_q[i];
      if (wr_en && (wr_ch == CH_W'(i))) begin
        shadow_d[i] = wr_duty;
      end
      active_d[i] = active_q[i];
      if (wrap) begin
`ifdef PWM_DYNAMIC_MULTI_FADE_EN
        if (active_q[i] < shadow_q[i]) begin
          active_d[i] = active_q[i] + RES'(1);
        end else if (active_q[i] > shadow_q[i]) begin
          active_d[i] = active_q[i] - RES'(1);
        end
`else
        active_d[i] = shadow_q[i];
`endif
      end
      pwm_d[i] = enable[i] && (cnt_q < active_q[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      presc_q      <= '0;
      cnt_q        <= '0;
      pwm          <= '0;
      period_start <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      presc_q      <= presc_d;
      cnt_q        <= cnt_d;
      pwm          <= pwm_d;
      period_start <= wrap;
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

endmodule

// File: tb/tb_pwm_dynamic_multi.sv
// Bench for pwm_dynamic_multi: two instances (PRESCALE 1 and 4) checked every cycle against an
// elapsed-time model, plus hand-computed high-time and period literals.
module tb_pwm_dynamic_multi;
  localparam int CH  = 4;
  localparam int PER = 15;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] enable;
  logic       wr_en;
  logic [2:0] wr_ch;
  logic [3:0] wr_duty;
  logic [3:0] pwm0, pwm1;
  logic       ps0, ps1;

  always #5 clock = ~clock;

  pwm_dynamic_multi #(.CHANNELS(4), .RES(4), .PRESCALE(1), .CH_W(3)) dut0 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_duty(wr_duty), .pwm(pwm0), .period_start(ps0)
  );

  pwm_dynamic_multi #(.CHANNELS(4), .RES(4), .PRESCALE(4), .CH_W(3)) dut1 (
    .clock(clock), .reset_n(reset_n), .enable(enable), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_duty(wr_duty), .pwm(pwm1), .period_start(ps1)
  );

  // Model state: clocks elapsed since reset, duty registers, expected outputs.
  int         presc [2] = '{1, 4};
  int         n [2];
  int         shadow [2][CH];
  int         active [2][CH];
  logic [3:0] epwm [2];
  logic       eps [2];
  int         checks = 0;
  int         errors = 0;
  int         hc0 [CH];
  int         hc1 [CH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    int  c;
    bit  wrap;
    for (int d = 0; d < 2; d++) begin
      if (!reset_n) begin
        n[d]    = 0;
        epwm[d] = '0;
        eps[d]  = 1'b0;
        for (int i = 0; i < CH; i++) begin
          shadow[d][i] = 0;
          active[d][i] = 0;
        end
      end else begin
        c = (n[d] / presc[d]) % PER;
        for (int i = 0; i < CH; i++) epwm[d][i] = enable[i] && (c < active[d][i]);
        wrap   = ((n[d] + 1) % presc[d] == 0) && (((n[d] + 1) / presc[d]) % PER == 0);
        eps[d] = wrap;
        if (wrap) begin
          for (int i = 0; i < CH; i++) begin
`ifdef PWM_DYNAMIC_MULTI_FADE_EN
            if (active[d][i] < shadow[d][i]) active[d][i]++;
            else if (active[d][i] > shadow[d][i]) active[d][i]--;
`else
            active[d][i] = shadow[d][i];
`endif
          end
        end
        if (wr_en && wr_ch < CH) shadow[d][wr_ch] = int'(wr_duty);
        n[d]++;
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check("pwm0", 32'(pwm0), 32'(epwm[0]));
    check("period_start0", 32'(ps0), 32'(eps[0]));
    check("pwm1", 32'(pwm1), 32'(epwm[1]));
    check("period_start1", 32'(ps1), 32'(eps[1]));
    for (int i = 0; i < CH; i++) begin
      hc0[i] += int'(pwm0[i]);
      hc1[i] += int'(pwm1[i]);
    end
  endtask

  task automatic clr_hc();
    for (int i = 0; i < CH; i++) begin
      hc0[i] = 0;
      hc1[i] = 0;
    end
  endtask

  task automatic window(input int len);
    clr_hc();
    repeat (len) step();
  endtask

  task automatic wr(input int ch, input int duty);
    wr_en   = 1'b1;
    wr_ch   = 3'(ch);
    wr_duty = 4'(duty);
    step();
    wr_en   = 1'b0;
  endtask

  // Steps until the selected instance pulses period_start; returns clocks waited.
  task automatic sync(input int d, output int waited);
    logic seen;
    waited = 0;
    seen   = 1'b0;
    while (!seen && waited < 200) begin
      step();
      waited++;
      seen = (d == 0) ? ps0 : ps1;
    end
    check("sync_period_start", 32'(seen), 32'd1);
  endtask

  initial begin
    int w;
    reset_n = 1'b0;
    enable  = 4'h0;
    wr_en   = 1'b0;
    wr_ch   = '0;
    wr_duty = '0;
    repeat (3) step();
    check("reset_pwm0", 32'(pwm0), 32'd0);
    check("reset_pwm1", 32'(pwm1), 32'd0);
    check("reset_ps0", 32'(ps0), 32'd0);
    reset_n = 1'b1;
    enable  = 4'hF;

    // Four channels at 5/0/15/8
    wr(0, 5); wr(1, 0); wr(2, 15); wr(3, 8);
    sync(0, w);
    sync(0, w);
    check("period_interval", 32'(w), 32'd15);
    window(PER);
`ifndef PWM_DYNAMIC_MULTI_FADE_EN
    check("t1_high_ch0", 32'(hc0[0]), 32'd5);
    check("t1_high_ch1", 32'(hc0[1]), 32'd0);
    check("t1_high_ch2", 32'(hc0[2]), 32'd15);
    check("t1_high_ch3", 32'(hc0[3]), 32'd8);
`endif

    // Two writes in one period: current period untouched, last write wins next
    clr_hc();
    repeat (4) step();
    wr(0, 12);
    step();
    wr(0, 3);
    repeat (8) step();
`ifndef PWM_DYNAMIC_MULTI_FADE_EN
    check("t2_high_cur", 32'(hc0[0]), 32'd5);
`endif
    window(PER);
`ifndef PWM_DYNAMIC_MULTI_FADE_EN
    check("t2_high_next", 32'(hc0[0]), 32'd3);
`endif

    // Write landing on the wrap edge takes effect one period later
    repeat (14) step();
    wr(1, 10);
    check("t3_wrap_cycle", 32'(ps0), 32'd1);
    window(PER);
`ifndef PWM_DYNAMIC_MULTI_FADE_EN
    check("t3_high_old", 32'(hc0[1]), 32'd0);
`endif
    window(PER);
`ifndef PWM_DYNAMIC_MULTI_FADE_EN
    check("t3_high_new", 32'(hc0[1]), 32'd10);
`endif

    // Out-of-range channel write is ignored
    clr_hc();
    wr(5, 9);
    repeat (14) step();
    for (int p = 0; p < 3; p++) begin
`ifndef PWM_DYNAMIC_MULTI_FADE_EN
      check("t4_ch0", 32'(hc0[0]), 32'd3);
      check("t4_ch1", 32'(hc0[1]), 32'd10);
      check("t4_ch2", 32'(hc0[2]), 32'd15);
      check("t4_ch3", 32'(hc0[3]), 32'd8);
`endif
      if (p < 2) window(PER);
    end

    // Enable gating mid-period, resume at current phase
    clr_hc();
    repeat (5) step();
    enable = 4'hB;
    step();
    check("t4_disable_low", 32'(pwm0[2]), 32'd0);
    repeat (3) step();
    enable = 4'hF;
    step();
`ifndef PWM_DYNAMIC_MULTI_FADE_EN
    check("t4_resume_high", 32'(pwm0[2]), 32'd1);
`endif
    repeat (5) step();
`ifndef PWM_DYNAMIC_MULTI_FADE_EN
    check("t4_gated_high", 32'(hc0[2]), 32'd11);
`endif

    // PRESCALE=4 instance: 60-clock period, duty 5 -> 20 clocks high
    wr(0, 5);
    sync(1, w);
    sync(1, w);
    check("t5_period_interval", 32'(w), 32'd60);
    window(60);
`ifndef PWM_DYNAMIC_MULTI_FADE_EN
    check("t5_high_ch0", 32'(hc1[0]), 32'd20);
`endif
    repeat (10) step();
    reset_n = 1'b0;
    step();
    check("t5_reset_pwm0", 32'(pwm0), 32'd0);
    check("t5_reset_pwm1", 32'(pwm1), 32'd0);
    reset_n = 1'b1;
    sync(1, w);
    check("t5_first_period", 32'(w), 32'd60);

`ifdef PWM_DYNAMIC_MULTI_FADE_EN
    // Fade: ramp 2 -> 6, then back to 4
    wr(0, 2);
    sync(0, w);
    sync(0, w);
    wr(0, 6);
    sync(0, w);
    begin
      int exp_up [5] = '{3, 4, 5, 6, 6};
      int exp_dn [3] = '{5, 4, 4};
      for (int k = 0; k < 5; k++) begin
        window(PER);
        check("t6_fade_up", 32'(hc0[0]), 32'(exp_up[k]));
      end
      wr(0, 4);
      sync(0, w);
      for (int k = 0; k < 3; k++) begin
        window(PER);
        check("t6_fade_down", 32'(hc0[0]), 32'(exp_dn[k]));
      end
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
